// File: rtl/modulo_teclado.sv
// modulo_teclado: 4x4 matrix keypad scanner and encoder for the calculator front end.
// Scans one column at a time, debounces press and release, and emits one pulse per key press.
module modulo_teclado #(
  parameter int unsigned SCAN_DIV        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] filas_i,
  output logic [3:0] columnas_o,
  output logic [3:0] nuevo_numero_o,
  output logic       numero_en_o,
  output logic [1:0] operacion_o,
  output logic       tecla_op_en_o,
  output logic       igual_en_o,
  output logic       borrar_en_o,
  output logic       tecla_presionada_o
);

  // state    | meaning
  // SCAN     | walk the columns, sample rows on the last cycle of each dwell
  // DEBOUNCE | column held, count stable cycles of the single latched row
  // EMIT     | one cycle, the event pulse is high
  // RELEASE  | column held, count consecutive idle cycles before rescanning
  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    K_DIGITO = 2'd0,
    K_OPER   = 2'd1,
    K_IGUAL  = 2'd2,
    K_BORRAR = 2'd3
  } tipo_t;

  localparam int unsigned SW = $clog2(SCAN_DIV + 1);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV);
  localparam logic [DW-1:0] DEB_EMIT  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CYCLES);

  state_t        state_q, state_d;
  logic [3:0]    filas_m_q, filas_s_q;
  logic [1:0]    col_q, col_d;
  logic [1:0]    fila_q, fila_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  logic [3:0]    nuevo_numero_q, nuevo_numero_d;
  logic [1:0]    operacion_q, operacion_d;
  logic          numero_en_q, numero_en_d;
  logic          tecla_op_en_q, tecla_op_en_d;
  logic          igual_en_q, igual_en_d;
  logic          borrar_en_q, borrar_en_d;
  logic          tecla_q, tecla_d;

  logic          una_fila;
  logic [1:0]    fila_baja;
  logic [3:0]    patron_fila;
  logic [DW-1:0] deb_inc;
  logic [SW-1:0] scan_inc;
  tipo_t         tipo;
  logic [3:0]    valor;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= SCAN;
      filas_m_q      <= 4'b0000;
      filas_s_q      <= 4'b0000;
      col_q          <= 2'd0;
      fila_q         <= 2'd0;
      scan_cnt_q     <= '0;
      deb_cnt_q      <= '0;
      nuevo_numero_q <= 4'd0;
      operacion_q    <= 2'd0;
      numero_en_q    <= 1'b0;
      tecla_op_en_q  <= 1'b0;
      igual_en_q     <= 1'b0;
      borrar_en_q    <= 1'b0;
      tecla_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      filas_m_q      <= filas_i;
      filas_s_q      <= filas_m_q;
      col_q          <= col_d;
      fila_q         <= fila_d;
      scan_cnt_q     <= scan_cnt_d;
      deb_cnt_q      <= deb_cnt_d;
      nuevo_numero_q <= nuevo_numero_d;
      operacion_q    <= operacion_d;
      numero_en_q    <= numero_en_d;
      tecla_op_en_q  <= tecla_op_en_d;
      igual_en_q     <= igual_en_d;
      borrar_en_q    <= borrar_en_d;
      tecla_q        <= tecla_d;
    end
  end

  // Row pattern helpers and saturating increments shared by the FSM.
  always_comb begin
    una_fila  = ($countones(~filas_s_q) == 1);
    fila_baja = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!filas_s_q[i]) fila_baja = 2'(i);
    end
    patron_fila = ~(4'b0001 << fila_q);
    deb_inc     = (deb_cnt_q == DEB_DONE) ? deb_cnt_q : deb_cnt_q + DW'(1);
    scan_inc    = (scan_cnt_q == SCAN_MAX) ? scan_cnt_q : scan_cnt_q + SW'(1);
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    fila_d     = fila_q;
    scan_cnt_d = '0;
    deb_cnt_d  = deb_cnt_q;
    unique case (state_q)
      SCAN: begin
        if (scan_cnt_q >= SCAN_LAST) begin
          if (una_fila) begin
            fila_d    = fila_baja;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_inc;
        end
      end
      DEBOUNCE: begin
        if (filas_s_q == patron_fila) begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DEB_EMIT) state_d = EMIT;
        end else begin
          deb_cnt_d = '0;
          col_d     = col_q + 2'd1;
          state_d   = SCAN;
        end
      end
      EMIT: begin
        deb_cnt_d = '0;
        state_d   = RELEASE;
      end
      RELEASE: begin
        if (filas_s_q == 4'b1111) begin
          deb_cnt_d = deb_inc;
          if (deb_inc >= DEB_DONE) begin
            deb_cnt_d = '0;
            col_d     = col_q + 2'd1;
            state_d   = SCAN;
          end
        end else begin
          deb_cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Key map: column 3 holds the operators, row 3 holds '*', '0' and '#'.
  always_comb begin
    tipo  = K_DIGITO;
    valor = 4'd0;
    if (col_q == 2'd3) begin
      tipo  = K_OPER;
      valor = {2'b00, fila_q};
    end else if (fila_q != 2'd3) begin
      valor = {2'b00, fila_q} * 4'd3 + {2'b00, col_q} + 4'd1;
    end else begin
      unique case (col_q)
        2'd0:    tipo = K_BORRAR;
        2'd1:    tipo = K_DIGITO;
        default: tipo = K_IGUAL;
      endcase
    end
  end

  // Pulses are registered on the edge entering EMIT so they are high during EMIT.
  always_comb begin
    nuevo_numero_d = nuevo_numero_q;
    operacion_d    = operacion_q;
    numero_en_d    = 1'b0;
    tecla_op_en_d  = 1'b0;
    igual_en_d     = 1'b0;
    borrar_en_d    = 1'b0;
    tecla_d        = tecla_q;
    if (state_d == EMIT) begin
      tecla_d = 1'b1;
      unique case (tipo)
        K_DIGITO: begin
          numero_en_d    = 1'b1;
          nuevo_numero_d = valor;
        end
        K_OPER: begin
          tecla_op_en_d = 1'b1;
          operacion_d   = valor[1:0];
        end
        K_IGUAL:  igual_en_d  = 1'b1;
        default:  borrar_en_d = 1'b1;
      endcase
    end
    if (state_q == RELEASE && state_d == SCAN) tecla_d = 1'b0;
  end

  assign columnas_o         = ~(4'b0001 << col_q);
  assign nuevo_numero_o     = nuevo_numero_q;
  assign numero_en_o        = numero_en_q;
  assign operacion_o        = operacion_q;
  assign tecla_op_en_o      = tecla_op_en_q;
  assign igual_en_o         = igual_en_q;
  assign borrar_en_o        = borrar_en_q;
  assign tecla_presionada_o = tecla_q;

endmodule

// File: tb/tb_modulo_teclado.sv
// tb_modulo_teclado: keypad scanner bench with a physical keypad model and an event-level reference.
// Directed scenarios plus randomized press/bounce sequences, all compared through comprobar().
module tb_modulo_teclado;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] nuevo_numero;
  logic       numero_en;
  logic [1:0] operacion;
  logic       tecla_op_en;
  logic       igual_en;
  logic       borrar_en;
  logic       tecla_presionada;

  logic [15:0] pulsadas = 16'h0000;

  int n_chk = 0;
  int n_ok  = 0;
  int n_solape = 0;
  int n_colbad = 0;
  int exp_num = 0;
  int exp_op  = 0;

  typedef struct {
    int tipo;
    int valor;
  } ev_t;
  ev_t evq[$];

  modulo_teclado #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .filas_i           (filas),
    .columnas_o        (columnas),
    .nuevo_numero_o    (nuevo_numero),
    .numero_en_o       (numero_en),
    .operacion_o       (operacion),
    .tecla_op_en_o     (tecla_op_en),
    .igual_en_o        (igual_en),
    .borrar_en_o       (borrar_en),
    .tecla_presionada_o(tecla_presionada)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    filas = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pulsadas[r*4+c] && !columnas[c]) filas[r] = 1'b0;
  end

  always @(negedge clk) begin
    int n;
    n = int'(numero_en) + int'(tecla_op_en) + int'(igual_en) + int'(borrar_en);
    if (n > 1) n_solape++;
    if (numero_en)   evq.push_back('{0, int'(nuevo_numero)});
    if (tecla_op_en) evq.push_back('{1, int'(operacion)});
    if (igual_en)    evq.push_back('{2, 0});
    if (borrar_en)   evq.push_back('{3, 0});
    if (!(columnas inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) n_colbad++;
  end

  task automatic comprobar(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic esperar(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic aplicar_reset();
    reset = 1'b1;
    esperar(3);
    reset = 1'b0;
  endtask

  // Reference key map: tipo 0 digit, 1 operator, 2 equals, 3 clear.
  function automatic void modelo_tecla(input int r, input int c, output int tipo, output int valor);
    if (c == 3) begin
      tipo = 1; valor = r;
    end else if (r < 3) begin
      tipo = 0; valor = 3 * r + c + 1;
    end else if (c == 0) begin
      tipo = 3; valor = 0;
    end else if (c == 1) begin
      tipo = 0; valor = 0;
    end else begin
      tipo = 2; valor = 0;
    end
  endfunction

  task automatic pulsar(input string tag, input int r, input int c, input int hold, input int idle,
                        input int n_glitch, input int glitch);
    int t, v;
    evq.delete();
    repeat (n_glitch) begin
      pulsadas[r*4+c] = 1'b1;
      esperar(glitch);
      pulsadas[r*4+c] = 1'b0;
      esperar(3);
    end
    pulsadas[r*4+c] = 1'b1;
    esperar(hold);
    pulsadas[r*4+c] = 1'b0;
    esperar(idle);
    modelo_tecla(r, c, t, v);
    comprobar({tag, "_n_eventos"}, evq.size(), 1);
    if (evq.size() > 0) begin
      comprobar({tag, "_tipo"}, evq[0].tipo, t);
      comprobar({tag, "_valor"}, evq[0].valor, v);
    end
    if (t == 0) exp_num = v;
    if (t == 1) exp_op = v;
    comprobar({tag, "_nuevo_numero"}, int'(nuevo_numero), exp_num);
    comprobar({tag, "_operacion"}, int'(operacion), exp_op);
    comprobar({tag, "_tecla_presionada"}, int'(tecla_presionada), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n_lat;
    int encontrado;
    int visto;

    // 1: reset values and idle column walk
    evq.delete();
    aplicar_reset();
    comprobar("rst_nuevo_numero", int'(nuevo_numero), 0);
    comprobar("rst_operacion", int'(operacion), 0);
    comprobar("rst_tecla_presionada", int'(tecla_presionada), 0);
    comprobar("rst_numero_en", int'(numero_en), 0);
    for (int i = 0; i < 16; i++) begin
      comprobar("columnas_paso", int'(columnas), 15 & ~(1 << ((i / SCAN_DIV) % 4)));
      esperar(1);
    end
    esperar(48);
    comprobar("reposo_sin_pulsos", evq.size(), 0);

    // 2: '7' held, then release timing of tecla_presionada
    evq.delete();
    pulsadas[8] = 1'b1;
    esperar(40);
    comprobar("t2_tecla_alta", int'(tecla_presionada), 1);
    pulsadas[8] = 1'b0;
    esperar(DEB + 1);
    comprobar("t2_tecla_antes_fin", int'(tecla_presionada), 1);
    esperar(1);
    comprobar("t2_tecla_fin", int'(tecla_presionada), 0);
    esperar(10);
    comprobar("t2_n_eventos", evq.size(), 1);
    if (evq.size() > 0) begin
      comprobar("t2_tipo", evq[0].tipo, 0);
      comprobar("t2_valor", evq[0].valor, 7);
    end
    exp_num = 7;

    // 3: 'C' with bounce
    pulsar("t3", 2, 3, 60, 30, 3, 3);

    // 4: two keys in one column, then '#' with 'D' added while held
    evq.delete();
    pulsadas[0] = 1'b1;
    pulsadas[4] = 1'b1;
    esperar(60);
    pulsadas = 16'h0000;
    esperar(30);
    comprobar("t4_multitecla", evq.size(), 0);
    pulsadas[14] = 1'b1;
    esperar(40);
    pulsadas[15] = 1'b1;
    esperar(30);
    pulsadas = 16'h0000;
    esperar(30);
    comprobar("t4_n_eventos", evq.size(), 1);
    if (evq.size() > 0) comprobar("t4_tipo", evq[0].tipo, 2);

    // 5: short press on '0'
    evq.delete();
    pulsadas[13] = 1'b1;
    esperar(5);
    pulsadas[13] = 1'b0;
    esperar(30);
    comprobar("t5_sin_evento", evq.size(), 0);
    visto = 0;
    for (int i = 0; i < 40; i++) begin
      esperar(1);
      if (columnas == 4'b0111) visto = 1;
    end
    comprobar("t5_scan_sigue", visto, 1);

    // 6: reset landing on the '5' EMIT edge
    pulsadas[5] = 1'b1;
    aplicar_reset();
    n_lat = 0;
    encontrado = 0;
    for (int i = 1; i <= 200 && encontrado == 0; i++) begin
      esperar(1);
      if (numero_en) begin
        encontrado = 1;
        n_lat = i;
      end
    end
    comprobar("t6_detectado", encontrado, 1);
    if (n_lat < 2) n_lat = 20;
    pulsadas[5] = 1'b0;
    esperar(30);
    pulsadas[5] = 1'b1;
    aplicar_reset();
    esperar(n_lat - 1);
    evq.delete();
    reset = 1'b1;
    esperar(1);
    reset = 1'b0;
    comprobar("t6_pulso_descartado", int'(numero_en), 0);
    comprobar("t6_nuevo_numero_rst", int'(nuevo_numero), 0);
    comprobar("t6_tecla_rst", int'(tecla_presionada), 0);
    encontrado = 0;
    for (int i = 0; i < 200 && encontrado == 0; i++) begin
      esperar(1);
      if (evq.size() > 0) encontrado = 1;
    end
    comprobar("t6_redetectado", encontrado, 1);
    pulsadas[5] = 1'b0;
    esperar(30);
    comprobar("t6_n_eventos", evq.size(), 1);
    if (evq.size() > 0) comprobar("t6_valor", evq[0].valor, 5);
    exp_num = 5;
    exp_op  = 0;

    // random presses with optional bounce
    for (int k = 0; k < 24; k++) begin
      pulsar("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(45, 90)), int'($urandom_range(20, 40)),
             int'($urandom_range(0, 2)), int'($urandom_range(1, 5)));
    end

    comprobar("solape_pulsos", n_solape, 0);
    comprobar("columnas_onehot", n_colbad, 0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
